// File: rtl/rename_recover_ctrl_pkg.sv
// Shared widths, recovery state encoding and mapping-bus helpers for RAT recovery.
package rename_recover_ctrl_pkg;

    localparam int unsigned RR_ARCH_REGS = 32;
    localparam int unsigned RR_AREG_W    = 5;
    localparam int unsigned RR_PREG_W    = 7;
    localparam int unsigned RR_LANES     = 4;

    typedef enum logic [1:0] {
        StIdle   = 2'd0,
        StSettle = 2'd1,
        StWalk   = 2'd2,
        StDone   = 2'd3
    } rr_state_e;

    // Physical register held for architectural register i in a flattened mapping bus.
    function automatic logic [RR_PREG_W-1:0] arch_map_slice(
        input logic [RR_ARCH_REGS*RR_PREG_W-1:0] map,
        input int unsigned                       i
    );
        return map[i*RR_PREG_W +: RR_PREG_W];
    endfunction

endpackage

// File: rtl/rename_recover_ctrl_if.sv
// Flush request, committed mapping, RAT write port and status for the recovery controller.
interface rename_recover_ctrl_if
    import rename_recover_ctrl_pkg::*;
#(
    parameter int unsigned ARCH_REGS = RR_ARCH_REGS,
    parameter int unsigned AREG_W    = RR_AREG_W,
    parameter int unsigned PREG_W    = RR_PREG_W,
    parameter int unsigned LANES     = RR_LANES
);

    logic                        FlushReq;
    logic [ARCH_REGS*PREG_W-1:0] ArchMapIn;
    logic                        ArchSStop;
    logic [LANES-1:0]            RatWrEn;
    logic [LANES*AREG_W-1:0]     RatWrAddr;
    logic [LANES*PREG_W-1:0]     RatWrData;
    logic                        RenameStall;
    logic                        RecoverBusy;
    logic                        RecoverDone;

    // The recovery controller.
    modport master (
        input  FlushReq, ArchMapIn,
        output ArchSStop, RatWrEn, RatWrAddr, RatWrData, RenameStall, RecoverBusy, RecoverDone
    );

    // Commit, architectural table and rename side.
    modport slave (
        output FlushReq, ArchMapIn,
        input  ArchSStop, RatWrEn, RatWrAddr, RatWrData, RenameStall, RecoverBusy, RecoverDone
    );

endinterface

// File: rtl/rename_recover_lane.sv
// One RAT write lane: architectural index idx+LANE and its committed physical mapping.
module rename_recover_lane #(
    parameter int unsigned ARCH_REGS = 32,
    parameter int unsigned AREG_W    = 5,
    parameter int unsigned PREG_W    = 7,
    parameter int unsigned LANE      = 0
) (
    input  logic [AREG_W-1:0]           idx_i,
    input  logic                        walk_i,
    input  logic [ARCH_REGS*PREG_W-1:0] map_i,
    output logic [AREG_W-1:0]           addr_o,
    output logic [PREG_W-1:0]           data_o
);

    logic [AREG_W-1:0] addr;

    assign addr   = idx_i + AREG_W'(LANE);
    // Outputs held at zero outside the walk so the write port stays quiet.
    assign addr_o = walk_i ? addr : '0;
    assign data_o = walk_i ? map_i[addr*PREG_W +: PREG_W] : '0;

endmodule

// File: rtl/rename_recover_ctrl.sv
// After a flush, freezes the architectural table and copies its mappings into the RAT
// LANES entries per cycle while holding rename stalled.
module rename_recover_ctrl
    import rename_recover_ctrl_pkg::*;
#(
    parameter int unsigned ARCH_REGS = RR_ARCH_REGS,
    parameter int unsigned AREG_W    = RR_AREG_W,
    parameter int unsigned PREG_W    = RR_PREG_W,
    parameter int unsigned LANES     = RR_LANES
) (
    input logic                  Clk,
    input logic                  Rest,
    rename_recover_ctrl_if.master bus
);

    localparam logic [AREG_W-1:0] IdxStep = AREG_W'(LANES);
    localparam logic [AREG_W-1:0] IdxLast = AREG_W'(ARCH_REGS - LANES);

    rr_state_e         state_q, state_d;
    logic [AREG_W-1:0] idx_q, idx_d;
    logic              walk;

    always_ff @(posedge Clk) begin
        if (Rest) begin
            state_q <= StIdle;
            idx_q   <= '0;
        end else begin
            state_q <= state_d;
            idx_q   <= idx_d;
        end
    end

    always_comb begin
        state_d = state_q;
        idx_d   = idx_q;
        unique case (state_q)
            StIdle: begin
                if (bus.FlushReq) begin
                    state_d = StSettle;
                end
            end
            StSettle: begin
                state_d = StWalk;
                idx_d   = '0;
            end
            StWalk: begin
                idx_d = idx_q + IdxStep;
                if (idx_q == IdxLast) begin
                    state_d = StDone;
                end
            end
            StDone: begin
                state_d = StIdle;
            end
            default: begin
                state_d = StIdle;
            end
        endcase
        // A new flush anywhere restarts the walk from the settle bubble.
        if (bus.FlushReq) begin
            state_d = StSettle;
            idx_d   = '0;
        end
    end

    assign walk            = (state_q == StWalk);
    assign bus.ArchSStop   = (state_q == StSettle) || walk;
    assign bus.RecoverBusy = (state_q != StIdle);
    // An aborted walk must not report completion.
    assign bus.RecoverDone = (state_q == StDone) && !bus.FlushReq;
    assign bus.RenameStall = bus.FlushReq || (state_q != StIdle);
    assign bus.RatWrEn     = {LANES{walk}};

    logic [LANES*AREG_W-1:0] wr_addr;
    logic [LANES*PREG_W-1:0] wr_data;

    for (genvar k = 0; k < LANES; k++) begin : g_lane
        rename_recover_lane #(
            .ARCH_REGS (ARCH_REGS),
            .AREG_W    (AREG_W),
            .PREG_W    (PREG_W),
            .LANE      (k)
        ) u_lane (
            .idx_i  (idx_q),
            .walk_i (walk),
            .map_i  (bus.ArchMapIn),
            .addr_o (wr_addr[k*AREG_W +: AREG_W]),
            .data_o (wr_data[k*PREG_W +: PREG_W])
        );
    end

    assign bus.RatWrAddr = wr_addr;
    assign bus.RatWrData = wr_data;

endmodule

// File: tb/tb_rename_recover_ctrl.sv
// Bench for rename_recover_ctrl: 4-lane and 8-lane builds against a flush-age timeline model.
module tb_rename_recover_ctrl;
    import rename_recover_ctrl_pkg::*;

    logic         Clk;
    logic         rest;
    logic         flush;
    logic [223:0] flat_map;
    int           arch_map [32];
    int           n_tests;
    int           n_fail;
    int           since;  // cycles since the last accepted flush, -1 when none

    rename_recover_ctrl_if #(.LANES(4)) if4 ();
    rename_recover_ctrl_if #(.LANES(8)) if8 ();

    assign if4.FlushReq  = flush;
    assign if8.FlushReq  = flush;
    assign if4.ArchMapIn = flat_map;
    assign if8.ArchMapIn = flat_map;

    rename_recover_ctrl #(.LANES(4)) dut4 (
        .Clk  (Clk),
        .Rest (rest),
        .bus  (if4)
    );

    rename_recover_ctrl #(.LANES(8)) dut8 (
        .Clk  (Clk),
        .Rest (rest),
        .bus  (if8)
    );

    initial Clk = 1'b0;
    always #5 Clk = ~Clk;

    task automatic check(input string name, input logic [63:0] act, input logic [63:0] exp);
        n_tests++;
        if (act !== exp) begin
            n_fail++;
            $display("FAIL %s: got %0h want %0h", name, act, exp);
        end
    endtask

    task automatic step(input int n);
        repeat (n) begin
            @(posedge Clk);
            #1;
        end
    endtask

    task automatic load_map(input int mul, input int add);
        for (int i = 0; i < 32; i++) begin
            arch_map[i]          = (i * mul + add) % 128;
            flat_map[i*7 +: 7]   = 7'(arch_map[i]);
        end
    endtask

    // Flush at cycle t: settle at t+1, walk t+2..t+W+1, done at t+W+2.
    always @(posedge Clk) begin
        if (rest) begin
            since <= -1;
        end else if (flush) begin
            since <= 1;
        end else if (since >= 0 && since < 1000) begin
            since <= since + 1;
        end
    end

    function automatic void model_outs(
        input  int          lanes,
        input  int          s,
        input  logic        fl,
        output logic [63:0] en,
        output logic [63:0] addr,
        output logic [63:0] data,
        output logic        stop,
        output logic        busy,
        output logic        done,
        output logic        stall
    );
        int w = 32 / lanes;
        en   = '0;
        addr = '0;
        data = '0;
        if (s >= 2 && s <= w + 1) begin
            for (int k = 0; k < lanes; k++) begin
                int a = (s - 2) * lanes + k;
                en[k] = 1'b1;
                addr  = addr | (64'(a) << (k * 5));
                data  = data | (64'(arch_map_slice(flat_map, a)) << (k * 7));
            end
        end
        stop  = (s >= 1 && s <= w + 1);
        busy  = (s >= 1 && s <= w + 2);
        done  = (s == w + 2) && !fl;
        stall = fl || busy;
    endfunction

    always @(negedge Clk) begin
        logic [63:0] e_en, e_addr, e_data;
        logic        e_stop, e_busy, e_done, e_stall;
        model_outs(4, since, flush, e_en, e_addr, e_data, e_stop, e_busy, e_done, e_stall);
        check("m4_en", 64'(if4.RatWrEn), e_en);
        check("m4_addr", 64'(if4.RatWrAddr), e_addr);
        check("m4_data", 64'(if4.RatWrData), e_data);
        check("m4_stop", 64'(if4.ArchSStop), 64'(e_stop));
        check("m4_busy", 64'(if4.RecoverBusy), 64'(e_busy));
        check("m4_done", 64'(if4.RecoverDone), 64'(e_done));
        check("m4_stall", 64'(if4.RenameStall), 64'(e_stall));
        model_outs(8, since, flush, e_en, e_addr, e_data, e_stop, e_busy, e_done, e_stall);
        check("m8_en", 64'(if8.RatWrEn), e_en);
        check("m8_addr", 64'(if8.RatWrAddr), e_addr);
        check("m8_data", 64'(if8.RatWrData), e_data);
        check("m8_stop", 64'(if8.ArchSStop), 64'(e_stop));
        check("m8_busy", 64'(if8.RecoverBusy), 64'(e_busy));
        check("m8_done", 64'(if8.RecoverDone), 64'(e_done));
        check("m8_stall", 64'(if8.RenameStall), 64'(e_stall));
    end

    initial begin
        int done_cnt;
        n_tests = 0;
        n_fail  = 0;
        since   = -1;
        rest    = 1'b1;
        flush   = 1'b1;
        load_map(1, 64);

        // Reset held with a flush pending.
        step(3);
        check("rst_en", 64'(if4.RatWrEn), 64'd0);
        check("rst_addr", 64'(if4.RatWrAddr), 64'd0);
        check("rst_data", 64'(if4.RatWrData), 64'd0);
        check("rst_stop", 64'(if4.ArchSStop), 64'd0);
        check("rst_busy", 64'(if4.RecoverBusy), 64'd0);
        check("rst_done", 64'(if4.RecoverDone), 64'd0);
        check("rst8_en", 64'(if8.RatWrEn), 64'd0);
        rest  = 1'b0;
        flush = 1'b0;
        step(1);
        check("idle_stall", 64'(if4.RenameStall), 64'd0);
        step(3);
        check("idle_stall2", 64'(if4.RenameStall), 64'd0);

        // Basic recovery, flush at t.
        flush = 1'b1;
        #1;
        check("b_stall_t", 64'(if4.RenameStall), 64'd1);
        step(1);
        flush = 1'b0;
        check("b_settle_stop", 64'(if4.ArchSStop), 64'd1);
        check("b_settle_en", 64'(if4.RatWrEn), 64'd0);
        step(1);
        check("b_first_addr", 64'(if4.RatWrAddr), 64'({5'd3, 5'd2, 5'd1, 5'd0}));
        check("b_first_data", 64'(if4.RatWrData), 64'({7'd67, 7'd66, 7'd65, 7'd64}));
        check("b_first_en", 64'(if4.RatWrEn), 64'hf);
        step(3);
        check("b8_last_addr", 64'(if8.RatWrAddr),
              64'({5'd31, 5'd30, 5'd29, 5'd28, 5'd27, 5'd26, 5'd25, 5'd24}));
        step(1);
        check("b8_done_t6", 64'(if8.RecoverDone), 64'd1);
        step(3);
        check("b_last_addr", 64'(if4.RatWrAddr), 64'({5'd31, 5'd30, 5'd29, 5'd28}));
        check("b_last_data", 64'(if4.RatWrData), 64'({7'd95, 7'd94, 7'd93, 7'd92}));
        step(1);
        check("b_done_t10", 64'(if4.RecoverDone), 64'd1);
        check("b_done_stop", 64'(if4.ArchSStop), 64'd0);
        check("b_done_stall", 64'(if4.RenameStall), 64'd1);
        step(1);
        check("b_stall_t11", 64'(if4.RenameStall), 64'd0);
        check("b_done_t11", 64'(if4.RecoverDone), 64'd0);
        step(2);

        // Second flush mid-walk at t+5.
        flush = 1'b1;
        step(1);
        flush = 1'b0;
        step(4);
        flush = 1'b1;
        step(1);
        flush = 1'b0;
        check("mw_settle_stop", 64'(if4.ArchSStop), 64'd1);
        check("mw_settle_en", 64'(if4.RatWrEn), 64'd0);
        step(1);
        check("mw_restart_addr", 64'(if4.RatWrAddr), 64'({5'd3, 5'd2, 5'd1, 5'd0}));
        step(3);
        check("mw_no_done_t10", 64'(if4.RecoverDone), 64'd0);
        step(5);
        check("mw_done_t15", 64'(if4.RecoverDone), 64'd1);
        step(3);

        // Flush landing in the done cycle, with a different mapping.
        load_map(3, 5);
        flush = 1'b1;
        step(1);
        flush = 1'b0;
        step(9);
        flush = 1'b1;
        #1;
        check("dn_no_done_t10", 64'(if4.RecoverDone), 64'd0);
        step(1);
        flush = 1'b0;
        check("dn_settle_t11", 64'(if4.ArchSStop), 64'd1);
        check("dn_settle_en", 64'(if4.RatWrEn), 64'd0);
        step(9);
        check("dn_done_t20", 64'(if4.RecoverDone), 64'd1);
        step(2);

        // Flush during the settle bubble.
        flush = 1'b1;
        step(1);
        step(1);
        flush = 1'b0;
        check("st_resettle_en", 64'(if4.RatWrEn), 64'd0);
        step(9);
        check("st_done_t11", 64'(if4.RecoverDone), 64'd1);
        step(2);

        // Reset during the walk.
        flush = 1'b1;
        step(1);
        flush = 1'b0;
        step(3);
        rest = 1'b1;
        step(1);
        check("rw_en_t5", 64'(if4.RatWrEn), 64'd0);
        check("rw_stop_t5", 64'(if4.ArchSStop), 64'd0);
        rest     = 1'b0;
        done_cnt = 0;
        for (int i = 0; i < 12; i++) begin
            step(1);
            if (if4.RecoverDone === 1'b1) done_cnt++;
        end
        check("rw_no_done", 64'(done_cnt), 64'd0);

        $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
        $finish;
    end

endmodule
